// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - upstream pixel stream and frame RAM port bundle
//
// Purpose: groups the upstream write handshake and both frame RAM ports so the
// reader and its environment connect through one bundle.
// Signals:
//   wr_valid, wr_data[7:0], wr_ready        upstream RRRGGGBB pixel handshake
//   mem_wr_en, mem_wr_addr[17:0], mem_wr_data[7:0]  RAM write port
//   mem_rd_addr[17:0], mem_rd_data[7:0]     RAM read port (1-cycle read latency)
// Modports: slave = frame reader side, master = pixel source / RAM side.
interface vga_frame_reader_if;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        mem_wr_en;
  logic [17:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic [17:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;

  modport slave (
    input  wr_valid, wr_data, mem_rd_data,
    output wr_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
  );

  modport master (
    output wr_valid, wr_data, mem_rd_data,
    input  wr_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
  );
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - double-buffered 2x-scaled frame reader for a VGA controller
//
// Purpose: fills the back buffer of an external dual-port frame RAM from an
// upstream raster-order pixel stream and serves the front buffer to the VGA
// controller at 2x scale. Buffers swap only at a VSYNC start after a complete
// back frame has been written.
// Ports:
//   clock          25 MHz pixel clock
//   reset          synchronous, active-high
//   next_x/next_y  coordinates of the next pixel from the VGA controller
//   vsync          active-low VSYNC from the VGA controller
//   color_out      RRRGGGBB pixel to the controller (1 cycle after next_x/next_y)
//   frame_swapped  one-cycle pulse when front and back buffers are exchanged
//   bus            upstream stream and frame RAM ports (vga_frame_reader_if.slave)
module vga_frame_reader #(
  parameter int unsigned IMG_W        = 320,
  parameter int unsigned IMG_H        = 240,
  parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  input  logic               vsync,
  output logic [7:0]         color_out,
  output logic               frame_swapped,
  vga_frame_reader_if.slave  bus
);

  localparam logic [16:0] LAST_OFF = 17'(IMG_W * IMG_H - 1);

  typedef enum logic {FILL, PENDING} state_t;

  // row * IMG_W as a sum of shifted copies of row, one per set bit of IMG_W
  // (320 reduces to (row << 8) + (row << 6)).
  function automatic logic [16:0] row_times_w(input logic [8:0] row);
    logic [16:0] acc;
    acc = '0;
    for (int b = 0; b < 17; b++) begin
      if (IMG_W[b]) acc = acc + (17'(row) << b);
    end
    return acc;
  endfunction

  state_t      state_q, state_d;
  logic [16:0] wr_cnt_q, wr_cnt_d;
  logic        front_buf_q, front_buf_d;
  logic        vsync_dly_q, vsync_dly_d;   // vsync registered one cycle
  logic        swapped_q, swapped_d;
  logic        oob_q, oob_d;

  logic        accept;
  logic        vsync_start;
  logic [16:0] rd_off;
  logic        unused_lsbs;

  // Odd coordinates map onto the same source pixel as their even neighbour.
  assign unused_lsbs = next_x[0] ^ next_y[0];

  assign accept      = bus.wr_valid & bus.wr_ready;
  assign vsync_start = vsync_dly_q & ~vsync;
  assign rd_off      = row_times_w(next_y[9:1]) + 17'(next_x[9:1]);

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    front_buf_d = front_buf_q;
    vsync_dly_d = vsync;
    swapped_d   = 1'b0;
    oob_d       = (32'(next_x[9:1]) >= IMG_W) || (32'(next_y[9:1]) >= IMG_H);
    case (state_q)
      FILL: begin
        // A VSYNC start while filling is ignored: the display keeps showing
        // the old front buffer until the back frame is complete.
        if (accept) begin
          if (wr_cnt_q == LAST_OFF) begin
            wr_cnt_d = '0;
            state_d  = PENDING;
          end else begin
            wr_cnt_d = wr_cnt_q + 17'd1;
          end
        end
      end
      PENDING: begin
        if (vsync_start) begin
          front_buf_d = ~front_buf_q;
          swapped_d   = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      front_buf_q <= 1'b0;
      vsync_dly_q <= 1'b1;
      swapped_q   <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      front_buf_q <= front_buf_d;
      vsync_dly_q <= vsync_dly_d;
      swapped_q   <= swapped_d;
      oob_q       <= oob_d;
    end
  end

  // wr_ready is gated by reset directly so it is low during reset yet high in
  // the very first cycle after release.
  assign bus.wr_ready    = ~reset & (state_q == FILL);
  assign bus.mem_wr_en   = accept;
  assign bus.mem_wr_addr = {~front_buf_q, wr_cnt_q};
  assign bus.mem_wr_data = bus.wr_data;
  assign bus.mem_rd_addr = {front_buf_q, rd_off};

  assign color_out     = oob_q ? BORDER_COLOR : bus.mem_rd_data;
  assign frame_swapped = swapped_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader
module tb_vga_frame_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default-geometry instance
  logic       reset0;
  logic [9:0] nx0, ny0;
  logic       vs0;
  logic [7:0] col0;
  logic       sw0;
  vga_frame_reader_if bus0();

  vga_frame_reader u_dut0 (
    .clock(clock), .reset(reset0), .next_x(nx0), .next_y(ny0), .vsync(vs0),
    .color_out(col0), .frame_swapped(sw0), .bus(bus0)
  );

  // Small instance: 160x8, visible border colour
  logic       reset1;
  logic [9:0] nx1, ny1;
  logic       vs1;
  logic [7:0] col1;
  logic       sw1;
  vga_frame_reader_if bus1();

  vga_frame_reader #(.IMG_W(160), .IMG_H(8), .BORDER_COLOR(8'hA5)) u_dut1 (
    .clock(clock), .reset(reset1), .next_x(nx1), .next_y(ny1), .vsync(vs1),
    .color_out(col1), .frame_swapped(sw1), .bus(bus1)
  );

  // Frame RAM models: synchronous read, one cycle latency
  logic [7:0] ram0 [0:262143];
  logic [7:0] ram1 [0:262143];

  always @(posedge clock) begin
    if (bus0.mem_wr_en) ram0[bus0.mem_wr_addr] <= bus0.mem_wr_data;
    bus0.mem_rd_data <= ram0[bus0.mem_rd_addr];
  end

  always @(posedge clock) begin
    if (bus1.mem_wr_en) ram1[bus1.mem_wr_addr] <= bus1.mem_wr_data;
    bus1.mem_rd_data <= ram1[bus1.mem_rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference image written into the back buffer of instance 0
  logic [7:0] img0 [0:76799];

  int        errs, rd_errs, col_errs, swaps, cnt, cyc, x, y, off;
  logic [7:0] exp_col;
  bit        have_prev, in_img;
  int        cx [0:3] = '{639, 640, 0, 3};
  int        cy [0:3] = '{479, 0, 480, 5};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 262144; i++) begin
      ram0[i] = 8'($urandom);
      ram1[i] = 8'($urandom);
    end
    reset0 = 1'b1; nx0 = '0; ny0 = '0; vs0 = 1'b1;
    bus0.wr_valid = 1'b0; bus0.wr_data = '0;
    reset1 = 1'b1; nx1 = '0; ny1 = '0; vs1 = 1'b1;
    bus1.wr_valid = 1'b0; bus1.wr_data = '0;

    // ---------------- Instance 0: reset behaviour ----------------
    repeat (3) @(negedge clock);
    bus0.wr_valid = 1'b1;
    #1;
    chk("rst_wr_ready", bus0.wr_ready, 0);
    chk("rst_wr_en", bus0.mem_wr_en, 0);
    chk("rst_swapped", sw0, 0);

    @(negedge clock);
    reset0 = 1'b0; bus0.wr_valid = 1'b0; nx0 = 10'd3; ny0 = 10'd5;
    #1;
    chk("first_cycle_ready", bus0.wr_ready, 1);
    chk("rd_addr_3_5", bus0.mem_rd_addr, 18'h00281);
    @(negedge clock); #1;
    chk("rd_data_3_5", col0, ram0[18'h00281]);

    // ---------------- Instance 0: full frame stream ----------------
    errs = 0; swaps = 0;
    bus0.wr_valid = 1'b1;
    for (int i = 0; i < 76800; i++) begin
      bus0.wr_data = 8'($urandom);
      img0[i] = bus0.wr_data;
      #1;
      if (bus0.mem_wr_en !== 1'b1 || 32'(bus0.mem_wr_addr) != 32'h20000 + i ||
          bus0.mem_wr_data !== img0[i]) errs++;
      if (i == 0)     chk("stream_first_addr", bus0.mem_wr_addr, 18'h20000);
      if (i == 76799) chk("stream_last_addr", bus0.mem_wr_addr, 18'h32BFF);
      if (sw0) swaps++;
      @(negedge clock);
    end
    #1;
    chk("stream_errs", errs, 0);
    chk("ready_drops_after_last", bus0.wr_ready, 0);
    chk("pending_no_write", bus0.mem_wr_en, 0);
    repeat (5) begin
      @(negedge clock); #1;
      if (sw0 || bus0.mem_wr_en) swaps++;
    end
    chk("no_swap_before_vsync", swaps, 0);

    // ---------------- Instance 0: swap on VSYNC fall ----------------
    @(negedge clock);
    vs0 = 1'b0; bus0.wr_valid = 1'b0;
    #1;
    chk("swap_not_same_cycle", sw0, 0);
    @(negedge clock); #1;
    chk("swap_pulse", sw0, 1);
    chk("ready_after_swap", bus0.wr_ready, 1);
    chk("wr_addr_after_swap", bus0.mem_wr_addr, 18'h00000);
    chk("idle_no_write", bus0.mem_wr_en, 0);
    @(negedge clock); #1;
    chk("swap_single_cycle", sw0, 0);
    vs0 = 1'b1;

    // ---------------- Instance 0: random reads of the new front buffer ----------------
    rd_errs = 0; col_errs = 0; have_prev = 0; exp_col = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock); #1;
      if (have_prev && col0 !== exp_col) col_errs++;
      if (k < 4) begin
        x = cx[k]; y = cy[k];
      end else begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 524);
      end
      nx0 = 10'(x); ny0 = 10'(y);
      in_img = ((x / 2) < 320) && ((y / 2) < 240);
      off = (y / 2) * 320 + (x / 2);
      #1;
      if (in_img) begin
        if (32'(bus0.mem_rd_addr) != 32'h20000 + off) rd_errs++;
        exp_col = img0[off];
      end else begin
        exp_col = 8'h00;
      end
      have_prev = 1;
    end
    @(negedge clock); #1;
    if (col0 !== exp_col) col_errs++;
    chk("front_rd_addr_errs", rd_errs, 0);
    chk("front_color_errs", col_errs, 0);

    // ---------------- Instance 1: border handling ----------------
    @(negedge clock);
    reset1 = 1'b0; nx1 = 10'd400; ny1 = 10'd0;
    #1;
    chk("u1_first_ready", bus1.wr_ready, 1);
    @(negedge clock); #1;
    chk("border_x400", col1, 8'hA5);
    nx1 = 10'd10; ny1 = 10'd20;
    @(negedge clock); #1;
    chk("border_y20", col1, 8'hA5);
    nx1 = 10'd319; ny1 = 10'd15;
    #1;
    chk("u1_rd_addr_last_pix", bus1.mem_rd_addr, 18'(7 * 160 + 159));
    @(negedge clock); #1;
    chk("u1_last_pix_color", col1, ram1[18'(7 * 160 + 159)]);

    // ---------------- Instance 1: reset after 1000 beats ----------------
    bus1.wr_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus1.wr_data = 8'($urandom);
      @(negedge clock);
    end
    #1;
    chk("u1_addr_after_1000", bus1.mem_wr_addr, 18'h20000 + 18'd1000);
    reset1 = 1'b1;
    #1;
    chk("u1_rst_ready_low", bus1.wr_ready, 0);
    chk("u1_rst_no_write", bus1.mem_wr_en, 0);
    @(negedge clock);
    reset1 = 1'b0;
    #1;
    chk("u1_post_rst_ready", bus1.wr_ready, 1);
    chk("u1_post_rst_addr", bus1.mem_wr_addr, 18'h20000);
    chk("u1_post_rst_wr_en", bus1.mem_wr_en, 1);

    // ---------------- Instance 1: random valid, vsync noise while filling ----------------
    cnt = 0; cyc = 0; errs = 0;
    while (cnt < 1279 && cyc < 20000) begin
      bus1.wr_valid = ($urandom_range(0, 2) != 0);
      bus1.wr_data  = 8'($urandom);
      vs1 = ($urandom_range(0, 3) != 0);
      #1;
      if (bus1.mem_wr_en !== bus1.wr_valid) errs++;
      if (bus1.wr_valid) begin
        if (32'(bus1.mem_wr_addr) != 32'h20000 + cnt || bus1.mem_wr_data !== bus1.wr_data) errs++;
        cnt++;
      end
      if (sw1) errs++;
      @(negedge clock); #1;
      cyc++;
    end
    chk("u1_rand_in_budget", (cyc < 20000), 1);
    chk("u1_rand_errs", errs, 0);

    // Final beat coincident with a VSYNC fall: no swap yet
    bus1.wr_valid = 1'b0; vs1 = 1'b1;
    @(negedge clock);
    bus1.wr_valid = 1'b1; vs1 = 1'b0;
    #1;
    chk("u1_final_addr", bus1.mem_wr_addr, 18'h20000 + 18'd1279);
    chk("u1_final_wr_en", bus1.mem_wr_en, 1);
    @(negedge clock); #1;
    chk("coincident_no_swap", sw1, 0);
    chk("coincident_pending", bus1.wr_ready, 0);
    bus1.wr_valid = 1'b0;
    swaps = 0;
    repeat (3) begin
      @(negedge clock); #1;
      if (sw1) swaps++;
    end
    vs1 = 1'b1;
    repeat (3) begin
      @(negedge clock); #1;
      if (sw1) swaps++;
    end
    chk("no_swap_until_next_fall", swaps, 0);
    vs1 = 1'b0;
    @(negedge clock); #1;
    chk("late_swap_pulse", sw1, 1);
    chk("late_swap_wr_addr", bus1.mem_wr_addr, 18'h00000);
    chk("late_swap_ready", bus1.wr_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter IMG_W, default 320, source image width in pixels; the image is displayed at 2x scale.
REQ-002 Parameter IMG_H, default 240, source image height in lines.
REQ-003 Parameter BORDER_COLOR, default 8'h00, RRRGGGBB colour output outside the image area.
REQ-004 clock  input  1  25 MHz pixel clock, shared with the VGA controller.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 next_x  input  10  x-coordinate of the next pixel, from the VGA controller.
REQ-007 next_y  input  10  y-coordinate of the next pixel, from the VGA controller.
REQ-008 vsync  input  1  active-low VSYNC from the VGA controller.
REQ-009 color_out  output  8  RRRGGGBB pixel to the controller's color_in.
REQ-010 wr_valid  input  1  upstream pixel valid (raster order).
REQ-011 wr_data  input  8  upstream RRRGGGBB pixel.
REQ-012 wr_ready  output  1  module accepts wr_data this cycle.
REQ-013 frame_swapped  output  1  one-cycle pulse when the front and back buffers are exchanged.
REQ-014 mem_wr_en, mem_wr_addr[17:0], mem_wr_data[7:0]  outputs  write port to the external dual-port frame RAM.
REQ-015 mem_rd_addr[17:0]  output, mem_rd_data[7:0]  input  read port; synchronous read, data valid 1 cycle after the address.

Function
REQ-016 Address format SHALL be {buf_sel, off[16:0]}, where off = row*IMG_W + col; the multiply SHALL be built from shifts and adds (row<<8 + row<<6 for 320).
REQ-017 Read side SHALL drive mem_rd_addr combinationally as {front_buf, (next_y>>1)*IMG_W + (next_x>>1)}.
REQ-018 color_out SHALL equal mem_rd_data (latency 1 cycle from next_x/next_y), except as stated in REQ-019.
REQ-019 When (next_x>>1) >= IMG_W or (next_y>>1) >= IMG_H, an out-of-image flag SHALL be registered; while the flag is set, color_out SHALL be BORDER_COLOR in the following cycle.
REQ-020 Write-side FSM states: FILL (wr_ready=1) and PENDING (wr_ready=0).
REQ-021 In FILL, a beat SHALL be accepted when wr_valid & wr_ready.
REQ-022 On each accepted beat, mem_wr_en=1, mem_wr_addr={~front_buf, wr_cnt}, mem_wr_data=wr_data, and wr_cnt SHALL increment; this is combinational in the accept cycle.
REQ-023 When the accepted beat has wr_cnt == IMG_W*IMG_H-1: wr_cnt SHALL wrap to 0 and the state SHALL go to PENDING.
REQ-024 vsync SHALL be registered as vsync_d; a VSYNC start is vsync_d==1 && vsync==0.
REQ-025 In PENDING, on a VSYNC start: front_buf SHALL toggle, frame_swapped SHALL be 1 for one cycle, and the state SHALL return to FILL.
REQ-026 In FILL, a VSYNC start SHALL have no effect; the display keeps the old front buffer indefinitely.
REQ-027 Simultaneous final beat and VSYNC start: enter PENDING; the swap SHALL wait for the next VSYNC start.
REQ-028 mem_wr_en SHALL be 0 whenever no beat is accepted; wr_data SHALL be ignored when wr_valid=0.
REQ-029 front_buf SHALL change only at a VSYNC start, never mid-frame.

Reset
REQ-030 While reset=1, the following values SHALL hold:
- state=FILL, wr_cnt=0, front_buf=0, vsync_d=1
- wr_ready=0, mem_wr_en=0, frame_swapped=0
- out-of-image flag=0
REQ-031 wr_ready SHALL assert in the first cycle with reset=0.
REQ-032 Reset mid-fill SHALL discard the partial back frame; the next accepted beat SHALL be written to offset 0.
REQ-033 Reset SHALL NOT clear RAM contents.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- Reset, then stream 76800 beats with wr_valid held high: mem_wr_addr runs 0x20000..0x32BFF; wr_ready drops after the last beat; frame_swapped stays 0 until the next vsync fall.
- vsync 1->0 while PENDING: frame_swapped pulses once; front_buf=1; wr_ready=1 next cycle; next write address 0x00000.
- next_x=3, next_y=5, front_buf=0: mem_rd_addr=0x00281 (2*320+1); color_out equals mem_rd_data one cycle later.
- IMG_W=160, next_x=400: color_out=BORDER_COLOR one cycle later.
- Final beat coincident with vsync fall: no swap; swap occurs on the following vsync fall.
- Reset asserted after 1000 beats: wr_cnt=0, front_buf unchanged (0), first post-reset write at 0x20000.
- wr_valid toggled randomly: write address increments only on accepted beats; no address is skipped or duplicated.
